ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter AW, default 8, RAM address width in bits.
REQ-002 Parameter DW, default 8, RAM data width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  access request, port 0 (processor controller) and port 1 (host/loader).
REQ-006 wr0, wr1  input  1 each  1 = write, 0 = read, per port.
REQ-007 addr0, addr1  input  AW each  access address, per port.
REQ-008 wdata0, wdata1  input  DW each  write data, per port.
REQ-009 gnt0, gnt1  output  1 each  port owns the RAM for the current transaction.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse, per port.
REQ-011 rdata0, rdata1  output  DW each  read data, valid while the matching ack is high.
REQ-012 cs_ram, wr_ram  output  1 each  RAM chip select and write strobe.
REQ-013 addr_ram  output  AW  RAM address; din_ram  output  DW  RAM write data.
REQ-014 dout_ram  input  DW  RAM read data, valid one cycle after the cs_ram cycle (synchronous read).
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, ACC, RESP, ACK; all outputs registered; no combinational input-to-output path.
REQ-017 IDLE, no req high: remain in IDLE with all strobes, gnt and ack at 0.
REQ-018 IDLE, exactly one req high: that port wins.
REQ-019 IDLE, both req high: the port not served last wins; last-served pointer updates to the winner.
REQ-020 On win (edge ending cycle T): latch winner's wr, addr and wdata; set gnt_winner=1; go to ACC.
REQ-021 ACC (cycle T+1): cs_ram=1, wr_ram=latched wr, addr_ram=latched addr, din_ram=latched wdata; next RESP.
REQ-022 RESP (cycle T+2): cs_ram=0, wr_ram=0; on a read, capture dout_ram into the winner's rdata register; next ACK.
REQ-023 ACK (cycle T+3): ack_winner=1 for exactly one cycle; gnt_winner falls at the end of ACK; next IDLE.
REQ-024 Latency: req sampled at T -> ack at T+3; transaction-to-transaction spacing 4 cycles minimum.
REQ-025 rdata of the non-winning port is unchanged; on a write, the winner's rdata is also unchanged.
REQ-026 Requester holds req, wr, addr and wdata stable until ack; values are latched at the win, so later changes have no effect on the transaction in progress.
REQ-027 Requester drops req in the cycle after ack, unless it is issuing a new request; a req still high in IDLE starts a new transaction.
REQ-028 req deasserted before ack does not abort the transaction; the transaction still completes and acks.
REQ-029 gnt0 and gnt1 never high together; ack0 and ack1 never high together.
REQ-030 Fairness: with both ports requesting continuously, grants alternate 0,1,0,1; no port waits more than one transaction.
REQ-031 cs_ram is high for exactly one cycle per transaction; wr_ram is high only when cs_ram is high.

Reset
REQ-032 While rst is high: state=IDLE; gnt0, gnt1, ack0, ack1, cs_ram, wr_ram and busy=0; addr_ram, din_ram, rdata0 and rdata1=0; last-served pointer=port 1, so port 0 wins the first tie.
REQ-033 rst asserted mid-transaction: RAM strobes drop asynchronously; the transaction is discarded with no ack; a write whose ACC cycle had not yet reached a clock edge is not performed.
REQ-034 First arbitration decision occurs on the first rising edge after rst falls.

Verification
REQ-035 Single write: req0=1, wr0=1, addr0=0x12, wdata0=0xA5 sampled at T -> cs_ram=1, wr_ram=1, addr_ram=0x12, din_ram=0xA5 at T+1; ack0=1 at T+3; gnt1 stays 0.
REQ-036 Read back: after REQ-035, req1=1, wr1=0, addr1=0x12 -> cs_ram=1, wr_ram=0 at T+1; rdata1=0xA5 with ack1=1 at T+3.
REQ-037 Tie after reset: req0 and req1 rise in the same cycle -> port 0 served first, then port 1; with both held continuously, grant order is 0,1,0,1.
REQ-038 Reset mid-write: rst pulsed while in ACC -> cs_ram and wr_ram go to 0 immediately; no ack; the next access proceeds normally from IDLE.
REQ-039 Early release: req0 dropped during RESP -> ack0 still pulses at T+3; IDLE follows and no second transaction starts.
REQ-040 Protocol checks over random traffic: gnt0/gnt1 and ack0/ack1 mutually exclusive; exactly one cs_ram cycle per ack; busy=0 only in IDLE.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the shared RAM port.
// The arbiter takes the slave side; the requesters/RAM side takes the master side.
interface ram_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic          wr0;
    logic          wr1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          gnt0;
    logic          gnt1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          cs_ram;
    logic          wr_ram;
    logic [AW-1:0] addr_ram;
    logic [DW-1:0] din_ram;
    logic [DW-1:0] dout_ram;
    logic          busy;

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, dout_ram,
        output gnt0, gnt1, ack0, ack1, rdata0, rdata1,
        output cs_ram, wr_ram, addr_ram, din_ram, busy
    );

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, dout_ram,
        input  gnt0, gnt1, ack0, ack1, rdata0, rdata1,
        input  cs_ram, wr_ram, addr_ram, din_ram, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of one synchronous single-port RAM.
// Each transaction is win -> ACC -> RESP -> ACK; ties go to the port not served last.
module ram_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input logic          clk,
    input logic          rst,
    ram_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] ACK  = 2'd3;

    logic [1:0]    state;
    logic          last_port;
    logic          owner;
    logic          op_wr;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          cs_q;
    logic          wr_q;
    logic          busy_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] din_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          win_valid;
    logic          win_port;
    logic          win_wr;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Pick the winner; on a tie the port opposite the last served one wins.
    always_comb begin
        win_valid = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            win_port = ~last_port;
        end else begin
            win_port = bus.req1;
        end
        win_wr    = win_port ? bus.wr1    : bus.wr0;
        win_addr  = win_port ? bus.addr1  : bus.addr0;
        win_wdata = win_port ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_port <= 1'b1;
            owner     <= 1'b0;
            op_wr     <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            cs_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state     <= ACC;
                        owner     <= win_port;
                        last_port <= win_port;
                        op_wr     <= win_wr;
                        gnt0_q    <= ~win_port;
                        gnt1_q    <= win_port;
                        busy_q    <= 1'b1;
                        // Strobes are set here so they are registered during ACC.
                        cs_q      <= 1'b1;
                        wr_q      <= win_wr;
                        addr_q    <= win_addr;
                        din_q     <= win_wdata;
                    end
                end
                ACC: begin
                    cs_q  <= 1'b0;
                    wr_q  <= 1'b0;
                    state <= RESP;
                end
                RESP: begin
                    // The RAM read data is valid during this cycle only.
                    if (!op_wr) begin
                        if (owner) begin
                            rdata1_q <= bus.dout_ram;
                        end else begin
                            rdata0_q <= bus.dout_ram;
                        end
                    end
                    ack0_q <= ~owner;
                    ack1_q <= owner;
                    state  <= ACK;
                end
                ACK: begin
                    ack0_q <= 1'b0;
                    ack1_q <= 1'b0;
                    gnt0_q <= 1'b0;
                    gnt1_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.rdata0   = rdata0_q;
    assign bus.rdata1   = rdata1_q;
    assign bus.cs_ram   = cs_q;
    assign bus.wr_ram   = wr_q;
    assign bus.addr_ram = addr_q;
    assign bus.din_ram  = din_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random-traffic bench for ram_arbiter with a synchronous RAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the chip-select cycle.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] ram_dout = '0;
    assign bus.dout_ram = ram_dout;

    always @(posedge clk) begin
        if (bus.cs_ram) begin
            if (bus.wr_ram) mem[bus.addr_ram] <= bus.din_ram;
            ram_dout <= mem[bus.addr_ram];
        end
    end

    logic mon_en = 1'b0;
    int   viol = 0;
    int   cs_cycles = 0;
    int   ack_cycles = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.gnt0 && bus.gnt1) viol++;
            if (bus.ack0 && bus.ack1) viol++;
            if (bus.wr_ram && !bus.cs_ram) viol++;
            if (bus.busy !== (bus.gnt0 | bus.gnt1)) viol++;
            if (bus.cs_ram) cs_cycles++;
            if (bus.ack0 | bus.ack1) ack_cycles++;
        end
    end

    task automatic test_reset;
        rst = 1'b1;
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h01; bus.wdata0 = 8'h11;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 8'h02; bus.wdata1 = 8'h22;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.cs_ram, bus.wr_ram, bus.busy} !== 7'b0)
            begin errors++; $display("FAIL reset_strobes: got %b, expected 0000000",
                {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.cs_ram, bus.wr_ram, bus.busy}); end
        checks++;
        if ({bus.addr_ram, bus.din_ram} !== 16'h0000)
            begin errors++; $display("FAIL reset_ram_bus: got %h, expected 0000", {bus.addr_ram, bus.din_ram}); end
        checks++;
        if ({bus.rdata0, bus.rdata1} !== 16'h0000)
            begin errors++; $display("FAIL reset_rdata: got %h, expected 0000", {bus.rdata0, bus.rdata1}); end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        rst = 1'b0;
    endtask

    // Starts on the negedge where reset was released: the win is the first edge after it.
    task automatic test_single_write;
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h12; bus.wdata0 = 8'hA5;
        @(negedge clk);
        checks++;
        if ({bus.cs_ram, bus.wr_ram} !== 2'b11)
            begin errors++; $display("FAIL write_acc_strobes: got %b, expected 11", {bus.cs_ram, bus.wr_ram}); end
        checks++;
        if (bus.addr_ram !== 8'h12)
            begin errors++; $display("FAIL write_addr: got %h, expected 12", bus.addr_ram); end
        checks++;
        if (bus.din_ram !== 8'hA5)
            begin errors++; $display("FAIL write_din: got %h, expected a5", bus.din_ram); end
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101)
            begin errors++; $display("FAIL write_gnt_busy: got %b, expected 101", {bus.gnt0, bus.gnt1, bus.busy}); end
        @(negedge clk);
        checks++;
        if ({bus.cs_ram, bus.wr_ram, bus.ack0} !== 3'b000)
            begin errors++; $display("FAIL write_resp: got %b, expected 000", {bus.cs_ram, bus.wr_ram, bus.ack0}); end
        @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1, bus.gnt0, bus.gnt1} !== 4'b1010)
            begin errors++; $display("FAIL write_ack: got %b, expected 1010", {bus.ack0, bus.ack1, bus.gnt0, bus.gnt1}); end
        checks++;
        if (bus.rdata0 !== 8'h00)
            begin errors++; $display("FAIL write_rdata_kept: got %h, expected 00", bus.rdata0); end
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ack0, bus.gnt0, bus.busy} !== 3'b000)
            begin errors++; $display("FAIL write_idle: got %b, expected 000", {bus.ack0, bus.gnt0, bus.busy}); end
        checks++;
        if (mem[8'h12] !== 8'hA5)
            begin errors++; $display("FAIL write_mem: got %h, expected a5", mem[8'h12]); end
    endtask

    task automatic test_read_back;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 8'h12; bus.wdata1 = 8'hFF;
        @(negedge clk);
        checks++;
        if ({bus.cs_ram, bus.wr_ram, bus.gnt0, bus.gnt1} !== 4'b1001)
            begin errors++; $display("FAIL read_acc: got %b, expected 1001", {bus.cs_ram, bus.wr_ram, bus.gnt0, bus.gnt1}); end
        checks++;
        if (bus.addr_ram !== 8'h12)
            begin errors++; $display("FAIL read_addr: got %h, expected 12", bus.addr_ram); end
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ack0, bus.ack1} !== 2'b01)
            begin errors++; $display("FAIL read_ack: got %b, expected 01", {bus.ack0, bus.ack1}); end
        checks++;
        if (bus.rdata1 !== 8'hA5)
            begin errors++; $display("FAIL read_rdata1: got %h, expected a5", bus.rdata1); end
        checks++;
        if (bus.rdata0 !== 8'h00)
            begin errors++; $display("FAIL read_rdata0_kept: got %h, expected 00", bus.rdata0); end
        bus.req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0)
            begin errors++; $display("FAIL read_idle_busy: got %b, expected 0", bus.busy); end
    endtask

    task automatic test_tie;
        logic [1:0]    exp_pair;
        logic [DW-1:0] got_rd;
        logic [DW-1:0] exp_rd;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 8'h20;
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 8'h30;
        for (int k = 0; k < 4; k++) begin
            exp_pair = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_rd   = (k % 2 == 0) ? 8'h1C : 8'h0C;
            @(negedge clk);
            checks++;
            if ({bus.gnt0, bus.gnt1} !== exp_pair)
                begin errors++; $display("FAIL tie_grant_%0d: got %b, expected %b", k, {bus.gnt0, bus.gnt1}, exp_pair); end
            repeat (2) @(negedge clk);
            checks++;
            if ({bus.ack0, bus.ack1} !== exp_pair)
                begin errors++; $display("FAIL tie_ack_%0d: got %b, expected %b", k, {bus.ack0, bus.ack1}, exp_pair); end
            got_rd = (k % 2 == 0) ? bus.rdata0 : bus.rdata1;
            checks++;
            if (got_rd !== exp_rd)
                begin errors++; $display("FAIL tie_rdata_%0d: got %h, expected %h", k, got_rd, exp_rd); end
            if (k == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.busy !== 1'b0)
            begin errors++; $display("FAIL tie_idle_busy: got %b, expected 0", bus.busy); end
    endtask

    task automatic test_reset_mid_write;
        logic seen_ack;
        bus.req0 = 1'b1; bus.wr0 = 1'b1; bus.addr0 = 8'h40; bus.wdata0 = 8'h77;
        @(negedge clk);
        checks++;
        if ({bus.cs_ram, bus.wr_ram} !== 2'b11)
            begin errors++; $display("FAIL rstmid_acc: got %b, expected 11", {bus.cs_ram, bus.wr_ram}); end
        #1;
        rst = 1'b1;
        bus.req0 = 1'b0;
        #1;
        checks++;
        if ({bus.cs_ram, bus.wr_ram, bus.gnt0, bus.busy} !== 4'b0000)
            begin errors++; $display("FAIL rstmid_async_drop: got %b, expected 0000",
                {bus.cs_ram, bus.wr_ram, bus.gnt0, bus.busy}); end
        @(negedge clk);
        rst = 1'b0;
        seen_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ack0 | bus.ack1) seen_ack = 1'b1;
        end
        checks++;
        if (seen_ack !== 1'b0)
            begin errors++; $display("FAIL rstmid_no_ack: got %b, expected 0", seen_ack); end
        bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 8'h40;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ack1, bus.rdata1} !== {1'b1, 8'h7C})
            begin errors++; $display("FAIL rstmid_readback: got %h, expected 17c", {bus.ack1, bus.rdata1}); end
        bus.req1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early_release;
        logic activity;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 8'h12;
        repeat (2) @(negedge clk);
        bus.req0 = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ack0, bus.rdata0} !== {1'b1, 8'hA5})
            begin errors++; $display("FAIL early_ack: got %h, expected 1a5", {bus.ack0, bus.rdata0}); end
        activity = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy | bus.cs_ram | bus.gnt0) activity = 1'b1;
        end
        checks++;
        if (activity !== 1'b0)
            begin errors++; $display("FAIL early_no_restart: got %b, expected 0", activity); end
    endtask

    task automatic test_random_traffic;
        logic          rq [2];
        logic          w  [2];
        logic [AW-1:0] a  [2];
        logic [DW-1:0] d  [2];
        logic          ak [2];
        logic [DW-1:0] rd [2];
        int            wt [2];
        int            max_wait;
        max_wait = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            rq[p] = 1'b0; w[p] = 1'b0; a[p] = '0; d[p] = '0; wt[p] = 0;
        end
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            ak[0] = bus.ack0;   ak[1] = bus.ack1;
            rd[0] = bus.rdata0; rd[1] = bus.rdata1;
            for (int p = 0; p < 2; p++) begin
                if (rq[p]) begin
                    wt[p]++;
                    if (ak[p]) begin
                        if (w[p]) begin
                            ref_mem[a[p]] = d[p];
                        end else begin
                            checks++;
                            if (rd[p] !== ref_mem[a[p]])
                                begin errors++; $display("FAIL rand_rdata%0d addr %h: got %h, expected %h",
                                    p, a[p], rd[p], ref_mem[a[p]]); end
                        end
                        if (wt[p] > max_wait) max_wait = wt[p];
                        rq[p] = 1'b0;
                    end
                end
                if (!rq[p] && cyc < 360 && $urandom_range(0, 2) != 0) begin
                    rq[p] = 1'b1;
                    w[p]  = 1'($urandom_range(0, 1));
                    a[p]  = AW'($urandom_range(0, 15));
                    d[p]  = DW'($urandom);
                    wt[p] = 0;
                end
            end
            bus.req0 = rq[0]; bus.wr0 = w[0]; bus.addr0 = a[0]; bus.wdata0 = d[0];
            bus.req1 = rq[1]; bus.wr1 = w[1]; bus.addr1 = a[1]; bus.wdata1 = d[1];
        end
        mon_en = 1'b0;
        checks++;
        if (viol !== 0)
            begin errors++; $display("FAIL rand_protocol: got %0d violations, expected 0", viol); end
        checks++;
        if (cs_cycles !== ack_cycles)
            begin errors++; $display("FAIL rand_cs_per_ack: got %0d cs cycles, expected %0d", cs_cycles, ack_cycles); end
        checks++;
        if (ack_cycles < 20)
            begin errors++; $display("FAIL rand_activity: got %0d acks, expected at least 20", ack_cycles); end
        checks++;
        if (max_wait > 8)
            begin errors++; $display("FAIL rand_fairness: got wait %0d, expected at most 8", max_wait); end
        checks++;
        if ({rq[0], rq[1]} !== 2'b00)
            begin errors++; $display("FAIL rand_drained: got pending %b, expected 00", {rq[0], rq[1]}); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.wr0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.wr1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
        $display("[TB] ram_arbiter bench start");
        test_reset();
        test_single_write();
        test_read_back();
        test_tie();
        test_reset_mid_write();
        test_early_release();
        test_random_traffic();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
